// File: rtl/opg_stream.sv
// Origin-payload generator: fetches a frame from a synchronous ROM and streams
// it over valid/ready, with credit-limited issue into a small skid FIFO.
module opg_stream #(
  parameter int unsigned DW          = 1,
  parameter int unsigned AW          = 13,
  parameter int unsigned PAYLOAD_LEN = 4320,
  parameter int unsigned ROM_LAT     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] frame_len,
  input  logic          done_clr,
  output logic          rom_rd_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] do_data,
  output logic          do_vld,
  input  logic          do_rdy,
  output logic          do_last,
  output logic          busy,
  output logic          done,
  output logic          done_flag,
  output logic          err_busy,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned FIFO_DEPTH = ROM_LAT + 3;
  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               rd_en_q, start, issue, xfer, credit_ok, push, pop;
  logic [AW-1:0]      base_q, len_q, issued, eff_len;
  logic [ROM_LAT-1:0] vld_sr, last_sr;
  logic [CW-1:0]      inflight, fifo_count;
  logic [CW:0]        credit;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [DW:0]        mem [FIFO_DEPTH];
  logic [DW:0]        head;

  assign start     = rd_en & ~rd_en_q;
  assign eff_len   = (frame_len == '0) ? AW'(PAYLOAD_LEN) : frame_len;
  assign xfer      = do_vld & do_rdy;
  assign done      = xfer & do_last & ~abort;
  assign busy      = (state != IDLE);
  assign rom_rd_en = issue;
  assign rom_addr  = base_q + issued;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) inflight = inflight + CW'(vld_sr[i]);
  end

  // Every issued read already owns a FIFO slot, so the FIFO cannot overflow.
  assign credit    = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign credit_ok = credit < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (issued != len_q && credit_ok) begin
          issue = 1'b1;
          if (issued == len_q - AW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      issue     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_en_q   <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      err_busy  <= 1'b0;
      frame_cnt <= '0;
      done_flag <= 1'b0;
      vld_sr    <= '0;
      last_sr   <= '0;
    end else begin
      state    <= state_nxt;
      rd_en_q  <= rd_en;
      err_busy <= start & (state != IDLE) & ~abort;
      if (state == IDLE && start && !abort) begin
        base_q <= base_addr;
        len_q  <= eff_len;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + AW'(1);
      end
      if (done) frame_cnt <= frame_cnt + 16'd1;
      if (done)          done_flag <= 1'b1;
      else if (done_clr) done_flag <= 1'b0;
      // Clearing the tags drops any ROM returns still in flight.
      if (abort) begin
        vld_sr  <= '0;
        last_sr <= '0;
      end else begin
        vld_sr[0]  <= issue;
        last_sr[0] <= issue & (issued == len_q - AW'(1));
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
          vld_sr[i]  <= vld_sr[i-1];
          last_sr[i] <= last_sr[i-1];
        end
      end
    end
  end

  assign push = vld_sr[ROM_LAT-1] & ~abort;
  assign pop  = (fifo_count != '0) & (~do_vld | do_rdy) & ~abort;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_sr[ROM_LAT-1], rom_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      do_data    <= '0;
      do_vld     <= 1'b0;
      do_last    <= 1'b0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      do_vld     <= 1'b0;
      do_last    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
      if (pop) begin
        do_data <= head[DW-1:0];
        do_last <= head[DW];
        do_vld  <= 1'b1;
      end else if (do_rdy) begin
        do_vld  <= 1'b0;
        do_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opg_stream.sv
// Bench for opg_stream: ROM model, frame-level scoreboard, table of frames and
// hand-written sequences for latency, abort, busy restart, flag clear and reset.
module tb_opg_stream;
  localparam int DW = 8, AW = 13, LAT = 2, PLEN = 4320, CREDIT = LAT + 3;

  logic          clk, rst_n, rd_en, abort, done_clr, do_rdy;
  logic [AW-1:0] base_addr, frame_len, rom_addr;
  logic [DW-1:0] rom_data, do_data;
  logic          rom_rd_en, do_vld, do_last, busy, done, done_flag, err_busy;
  logic [15:0]   frame_cnt;

  opg_stream #(.DW(DW), .AW(AW), .PAYLOAD_LEN(PLEN), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .abort(abort),
    .base_addr(base_addr), .frame_len(frame_len), .done_clr(done_clr),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .do_data(do_data), .do_vld(do_vld), .do_rdy(do_rdy), .do_last(do_last),
    .busy(busy), .done(done), .done_flag(done_flag), .err_busy(err_busy),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int unsigned a);
    return 8'((a * 37 + (a >> 7) + 11) & 255);
  endfunction

  // ROM: data for an address read in cycle c is presented in cycle c+LAT.
  logic [LAT-1:0] pv;
  logic [AW-1:0]  pa [LAT];
  always @(posedge clk) begin
    pv[0] <= rom_rd_en;
    pa[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign rom_data = pv[LAT-1] ? rom_f(int'(pa[LAT-1])) : 8'hEE;

  typedef struct packed { logic [7:0] d; logic last; } word_t;
  typedef struct { int unsigned base; int unsigned flen; bit rnd; int unsigned exp_len; int unsigned exp_last; } vec_t;

  word_t       exp_q[$];
  word_t       e;
  int unsigned issue_base, issue_len, issue_idx, rx_cnt, err_cnt;
  logic [AW-1:0] last_addr;
  logic [15:0] exp_frames, saved_frames;
  logic        exp_flag, prev_stall, prev_abort, xfer, xfer_last, rnd_rdy;
  logic [7:0]  prev_data;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every transfer, issue and flag is checked against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_frames = '0;
      exp_flag   = 1'b0;
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end else begin
      xfer      = do_vld && do_rdy;
      xfer_last = 1'b0;
      chk("frame_cnt", frame_cnt, exp_frames);
      chk("done_flag", done_flag, exp_flag);
      if (err_busy) err_cnt++;
      if (prev_stall && !prev_abort) begin
        chk("hold_vld", do_vld, 1);
        chk("hold_data", do_data, prev_data);
      end
      if (rom_rd_en) begin
        chk("credit", (int'(issue_idx) - int'(rx_cnt) - int'(do_vld)) < CREDIT, 1);
        chk("issue_in_len", issue_idx < issue_len, 1);
        chk("rom_addr", rom_addr, (issue_base + issue_idx) % 8192);
        last_addr = rom_addr;
        issue_idx++;
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_word: got data %0h, expected no transfer (t=%0t)", do_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("do_data", do_data, e.d);
          chk("do_last", do_last, e.last);
          chk("done", done, e.last);
          rx_cnt++;
          if (e.last) begin
            xfer_last = 1'b1;
            exp_frames++;
          end
        end
      end else begin
        chk("done_quiet", done, 0);
      end
      if (xfer_last)     exp_flag = 1'b1;
      else if (done_clr) exp_flag = 1'b0;
      prev_stall = do_vld && !do_rdy;
      prev_data  = do_data;
      prev_abort = abort;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    do_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    issue_idx = 0;
    rx_cnt    = 0;
    issue_len = 0;
  endtask

  task automatic start_frame(input int unsigned base, input int unsigned flen);
    int unsigned l;
    step();
    l = (flen == 0) ? PLEN : flen;
    base_addr  = AW'(base);
    frame_len  = AW'(flen);
    rd_en      = 1'b1;
    issue_base = base;
    issue_len  = l;
    issue_idx  = 0;
    rx_cnt     = 0;
    for (int unsigned i = 0; i < l; i++)
      exp_q.push_back('{d: rom_f((base + i) % 8192), last: (i == l - 1)});
    step();
    rd_en = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input bit clr_on_done);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      done_clr = clr_on_done && do_vld && do_last;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    done_clr = 1'b0;
    chk("frame_complete", ok, 1);
  endtask

  task automatic wait_words(input int unsigned n);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (rx_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_word", ok, 1);
  endtask

  vec_t vecs[6];
  int   n, cnt;
  int unsigned rb, rl;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base: 0,    flen: 0,   rnd: 1'b0, exp_len: 4320, exp_last: 4319};
    vecs[1] = '{base: 8190, flen: 16,  rnd: 1'b0, exp_len: 16,   exp_last: 13};
    vecs[2] = '{base: 100,  flen: 100, rnd: 1'b1, exp_len: 100,  exp_last: 199};
    vecs[3] = '{base: 8191, flen: 1,   rnd: 1'b1, exp_len: 1,    exp_last: 8191};
    vecs[4] = '{base: 5,    flen: 2,   rnd: 1'b1, exp_len: 2,    exp_last: 6};
    vecs[5] = '{base: 4000, flen: 300, rnd: 1'b1, exp_len: 300,  exp_last: 4299};

    rst_n = 1'b0; rd_en = 1'b0; abort = 1'b0; done_clr = 1'b0; do_rdy = 1'b1;
    base_addr = '0; frame_len = '0; rnd_rdy = 1'b0; err_cnt = 0; last_addr = '0;
    clear_model();
    repeat (3) step();
    chk("reset_outputs", {rom_rd_en, rom_addr, do_data, do_vld, do_last, busy, done,
                          done_flag, err_busy, frame_cnt}, 0);
    rst_n = 1'b1;
    step();

    // First-word latency (ROM_LAT + 2 edges after the start-sampling edge) and burst length.
    start_frame(0, 8);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (do_vld) break;
      n++;
    end
    chk("latency", n, LAT + 2);
    cnt = 0;
    while (do_vld && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("burst_len", cnt, 8);
    wait_frame(100, 1'b0);

    foreach (vecs[i]) begin
      rnd_rdy = vecs[i].rnd;
      start_frame(vecs[i].base, vecs[i].flen);
      wait_frame(int'(vecs[i].exp_len) * 8 + 100, 1'b0);
      chk("words_rx", rx_cnt, vecs[i].exp_len);
      chk("last_addr", last_addr, vecs[i].exp_last);
    end
    chk("no_err_busy", err_cnt, 0);

    for (int k = 0; k < 5; k++) begin
      rb = $urandom_range(0, 8191);
      rl = $urandom_range(1, 160);
      rnd_rdy = 1'($urandom_range(0, 1));
      start_frame(rb, rl);
      wait_frame(int'(rl) * 8 + 100, 1'b0);
      chk("rand_words", rx_cnt, rl);
    end

    // Abort mid-frame, then a short frame.
    rnd_rdy = 1'b1;
    saved_frames = exp_frames;
    start_frame(300, 100);
    wait_words(40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    clear_model();
    @(negedge clk);
    chk("abort_vld", do_vld, 0);
    chk("abort_rd", rom_rd_en, 0);
    chk("abort_busy", busy, 0);
    repeat (8) step();
    chk("abort_cnt", frame_cnt, saved_frames);
    start_frame(7, 5);
    wait_frame(100, 1'b0);
    chk("post_abort_words", rx_cnt, 5);

    // Re-pulsed rd_en mid-frame, done_clr coinciding with completion.
    rnd_rdy = 1'b0;
    err_cnt = 0;
    start_frame(1000, 20);
    repeat (3) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    wait_frame(200, 1'b1);
    chk("err_busy_once", err_cnt, 1);
    chk("repulse_words", rx_cnt, 20);
    chk("flag_set_wins", done_flag, 1);
    step();
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    @(negedge clk);
    chk("flag_cleared", done_flag, 0);

    // Reset mid-frame.
    rnd_rdy = 1'b1;
    start_frame(50, 40);
    wait_words(10);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {rom_rd_en, rom_addr, do_data, do_vld, do_last, busy, done,
                           done_flag, err_busy, frame_cnt}, 0);
    clear_model();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("cnt_restart", frame_cnt, 0);
    start_frame(20, 12);
    wait_frame(200, 1'b0);
    chk("post_rst_words", rx_cnt, 12);
    chk("post_rst_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
